// File: rtl/block_data_memory.sv
// block_data_memory: 64 x 32-bit block memory serving the data cache miss port with a fixed access latency.
module block_data_memory #(
    parameter int LATENCY = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state;
    logic [3:0]  count;
    logic        op_write;
    logic [5:0]  addr_l;
    logic [31:0] wdata_l;
    logic [31:0] mem [64];
    assign busywait = !reset && ((state == IDLE && (read ^ write)) || state == BUSY);
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            readdata <= 32'h0;
            op_write <= 1'b0;
            addr_l   <= 6'd0;
            wdata_l  <= 32'h0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else begin
            case (state)
                IDLE: if (read ^ write) begin
                    op_write <= write;
                    addr_l   <= address;
                    wdata_l  <= writedata;
                    count    <= 4'd0;
                    state    <= BUSY;
                end
                BUSY: begin
                    count <= count + 4'd1;
                    // a dropped request aborts before any completion on the same edge
                    if (!read && !write) state <= IDLE;
                    else if (count == 4'(LATENCY - 1)) begin
                        if (op_write) mem[addr_l] <= wdata_l;
                        else readdata <= mem[addr_l];
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_data_memory.sv
// tb_block_data_memory: scoreboard bench for block_data_memory latency, data, abort, illegal and reset behaviour.
module tb_block_data_memory;
    localparam int L = 5;
    logic        clock = 1'b0;
    logic        reset, read, write;
    logic [5:0]  address;
    logic [31:0] writedata, readdata;
    logic        busywait;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [64];

    block_data_memory #(.LATENCY(L)) dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata),
        .readdata(readdata), .busywait(busywait)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Drives one request and returns busywait-high cycle count and readdata seen in DONE.
    task automatic run_access(input logic wr, input logic [5:0] a, input logic [31:0] d,
                              output int bw, output logic [31:0] rd);
        read = ~wr; write = wr; address = a; writedata = d;
        bw = 0; rd = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busywait) bw++;
            else if (bw > 0) begin
                rd = readdata;
                break;
            end
        end
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; read = 1'b1; write = 1'b0; address = 6'd5; writedata = 32'h0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        vectors++;
        if (busywait !== 1'b0) begin miscompares++; $display("FAIL reset_busywait got=%b want=0", busywait); end
        vectors++;
        if (readdata !== 32'h0) begin miscompares++; $display("FAIL reset_readdata got=%h want=00000000", readdata); end
        @(posedge clock); #1;
        reset = 1'b0; read = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_read_zero;
        int bw; logic [31:0] rd, e;
        exp_q.push_back(model[5]);
        run_access(1'b0, 6'd5, 32'h0, bw, rd);
        vectors++;
        if (bw !== L + 1) begin miscompares++; $display("FAIL read5_latency got=%0d want=%0d", bw, L + 1); end
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL read5_data got=%h want=%h", rd, e); end
    endtask

    task automatic test_write_read;
        int bw; logic [31:0] rd, e;
        run_access(1'b1, 6'h2A, 32'hDEADBEEF, bw, rd);
        model[6'h2A] = 32'hDEADBEEF;
        vectors++;
        if (bw !== L + 1) begin miscompares++; $display("FAIL write2a_latency got=%0d want=%0d", bw, L + 1); end
        exp_q.push_back(model[6'h2A]);
        run_access(1'b0, 6'h2A, 32'h0, bw, rd);
        vectors++;
        if (bw !== L + 1) begin miscompares++; $display("FAIL read2a_latency got=%0d want=%0d", bw, L + 1); end
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL read2a_data got=%h want=%h", rd, e); end
    endtask

    task automatic test_latched;
        int bw; logic [31:0] rd, e;
        bit done = 1'b0;
        read = 1'b0; write = 1'b1; address = 6'd3; writedata = 32'h11223344;
        @(posedge clock); #1;
        @(posedge clock); #1;
        address = 6'd4; writedata = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!busywait) begin done = 1'b1; break; end
        end
        @(posedge clock); #1;
        write = 1'b0;
        model[3] = 32'h11223344;
        vectors++;
        if (!done) begin miscompares++; $display("FAIL latched_done got=timeout want=done"); end
        exp_q.push_back(model[3]);
        run_access(1'b0, 6'd3, 32'h0, bw, rd);
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL latched_read3 got=%h want=%h", rd, e); end
        exp_q.push_back(model[4]);
        run_access(1'b0, 6'd4, 32'h0, bw, rd);
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL latched_read4 got=%h want=%h", rd, e); end
    endtask

    task automatic test_abort;
        int bw; logic [31:0] rd, e;
        run_access(1'b1, 6'd7, 32'hA5A5A5A5, bw, rd);
        model[7] = 32'hA5A5A5A5;
        run_access(1'b0, 6'h2A, 32'h0, bw, rd);
        read = 1'b1; write = 1'b0; address = 6'd7;
        for (int i = 0; i < 3; i++) begin @(posedge clock); #1; end
        read = 1'b0;
        @(negedge clock);
        vectors++;
        if (busywait !== 1'b1) begin miscompares++; $display("FAIL abort_busy_cycle got=%b want=1", busywait); end
        @(posedge clock); #1;
        @(negedge clock);
        vectors++;
        if (busywait !== 1'b0) begin miscompares++; $display("FAIL abort_busywait got=%b want=0", busywait); end
        vectors++;
        if (readdata !== model[6'h2A]) begin miscompares++; $display("FAIL abort_readdata got=%h want=%h", readdata, model[6'h2A]); end
        @(posedge clock); #1;
        exp_q.push_back(model[7]);
        run_access(1'b0, 6'd7, 32'h0, bw, rd);
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL abort_reread7 got=%h want=%h", rd, e); end
    endtask

    task automatic test_illegal;
        int bw; logic [31:0] rd, e;
        read = 1'b1; write = 1'b1; address = 6'h2A; writedata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            if (busywait !== 1'b0) begin miscompares++; $display("FAIL illegal_busywait cycle=%0d got=%b want=0", i, busywait); end
            @(posedge clock); #1;
        end
        read = 1'b0; write = 1'b0;
        exp_q.push_back(model[6'h2A]);
        run_access(1'b0, 6'h2A, 32'h0, bw, rd);
        vectors++;
        if (bw !== L + 1) begin miscompares++; $display("FAIL illegal_then_latency got=%0d want=%0d", bw, L + 1); end
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL illegal_mem got=%h want=%h", rd, e); end
    endtask

    task automatic test_reset_mid;
        int bw; logic [31:0] rd, e;
        read = 1'b0; write = 1'b1; address = 6'd9; writedata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if (busywait !== 1'b0) begin miscompares++; $display("FAIL midreset_busywait got=%b want=0", busywait); end
        @(posedge clock); #1;
        reset = 1'b0; write = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        @(posedge clock); #1;
        exp_q.push_back(model[9]);
        run_access(1'b0, 6'd9, 32'h0, bw, rd);
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL midreset_read9 got=%h want=%h", rd, e); end
        exp_q.push_back(model[6'h2A]);
        run_access(1'b0, 6'h2A, 32'h0, bw, rd);
        e = exp_q.pop_front();
        vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL midreset_clear2a got=%h want=%h", rd, e); end
    endtask

    task automatic test_back_to_back;
        int bw; logic [31:0] rd, d, e;
        logic [5:0] addrs [6];
        for (int i = 0; i < 6; i++) begin
            addrs[i] = 6'($urandom_range(0, 63));
            d = $urandom;
            run_access(1'b1, addrs[i], d, bw, rd);
            model[addrs[i]] = d;
            vectors++;
            if (bw !== L + 1) begin miscompares++; $display("FAIL b2b_write_latency i=%0d got=%0d want=%0d", i, bw, L + 1); end
        end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(model[addrs[i]]);
            run_access(1'b0, addrs[i], 32'h0, bw, rd);
            e = exp_q.pop_front();
            vectors++;
            if (rd !== e) begin miscompares++; $display("FAIL b2b_read addr=%0d got=%h want=%h", addrs[i], rd, e); end
        end
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 6'd0; writedata = 32'h0;
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        test_reset;
        test_read_zero;
        test_write_read;
        test_latched;
        test_abort;
        test_illegal;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
